rtc_bus_sequencer: RTL and testbench

- Controller for the RTC's multiplexed address/data parallel bus.
- Arbitrates between a configuration-write requester and a time-read requester, then runs one complete bus transaction per grant: an address phase followed by a data phase.
- Produces the cs_n/rd_n/wr_n/ad/dir strobes and the bus output value, and returns read data.
- Sits between the RTC register-access logic and the bus pads.

---
 rtl/rtc_bus_pkg.sv | 39 +++
 rtl/rtc_phase_timer.sv | 26 ++
 rtl/rtc_bus_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared states, ops and timing defaults for the RTC bus sequencer
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_GAP
    } busState_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } busOp_t;

    localparam int DEF_T_SETUP  = 2;
    localparam int DEF_T_STROBE = 6;
    localparam int DEF_T_HOLD   = 2;
    localparam int DEF_T_GAP    = 2;
    localparam int DEF_DW       = 8;

    // The counter only ever holds T-1, so clog2 of the longest phase is enough (min 1 bit).
    function automatic int phaseCntWidth(input int tSetup, input int tStrobe,
                                         input int tHold, input int tGap);
        int longest;
        longest = tSetup;
        if (tStrobe > longest) longest = tStrobe;
        if (tHold > longest) longest = tHold;
        if (tGap > longest) longest = tGap;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

    localparam int DEF_CNT_W = phaseCntWidth(DEF_T_SETUP, DEF_T_STROBE, DEF_T_HOLD, DEF_T_GAP);

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter pacing every timed bus state
module rtc_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clkAD,
    input  logic          resetAD,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clkAD) begin
        if (resetAD) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - arbitrated address/data transaction sequencer for the RTC parallel bus
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_GAP    = DEF_T_GAP,
    parameter int DW       = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    input  logic [DW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          cs_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          ad,
    output logic          dir,
    output logic [DW-1:0] bus_out,
    input  logic [DW-1:0] bus_in,
    output logic          busy
);

    localparam int CW = phaseCntWidth(T_SETUP, T_STROBE, T_HOLD, T_GAP);

    localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP    = CW'(T_GAP - 1);

    generate
        if (T_SETUP < 1 || T_STROBE < 1 || T_HOLD < 1 || T_GAP < 1) begin : gBadTiming
            $error("rtc_bus_sequencer: timing parameters must all be at least 1");
        end
    endgenerate

    busState_t     state;
    busState_t     nextState;
    busOp_t        opReg;
    busOp_t        lastGrant;
    busOp_t        grantOp;
    busOp_t        curOp;
    logic [DW-1:0] addrReg;
    logic [DW-1:0] dataReg;
    logic [DW-1:0] capReg;
    logic [DW-1:0] curAddr;
    logic [DW-1:0] curData;
    logic          timerLoad;
    logic [CW-1:0] timerVal;
    logic          timerDone;

    rtc_phase_timer #(
        .CW(CW)
    ) phaseTimer (
        .clkAD   (clk),
        .resetAD (reset),
        .load    (timerLoad),
        .loadVal (timerVal),
        .done    (timerDone)
    );

    // Under contention the requester that did not win last time gets the bus.
    assign grantOp = (wr_req && (!rd_req || lastGrant == OP_RD)) ? OP_WR : OP_RD;

    // Outputs are registered from the next state, so on the grant edge the latches are not yet loaded.
    assign curOp   = (state == ST_IDLE) ? grantOp : opReg;
    assign curAddr = (state == ST_IDLE) ? ((grantOp == OP_WR) ? wr_addr : rd_addr) : addrReg;
    assign curData = (state == ST_IDLE) ? wr_data : dataReg;

    always_comb begin
        nextState = state;
        timerLoad = 1'b0;
        timerVal  = '0;
        case (state)
            ST_IDLE: begin
                if (wr_req || rd_req) begin
                    nextState = ST_A_SETUP;
                    timerLoad = 1'b1;
                    timerVal  = LD_SETUP;
                end
            end
            ST_A_SETUP: begin
                if (timerDone) begin
                    nextState = ST_A_STROBE;
                    timerLoad = 1'b1;
                    timerVal  = LD_STROBE;
                end
            end
            ST_A_STROBE: begin
                if (timerDone) begin
                    nextState = ST_A_HOLD;
                    timerLoad = 1'b1;
                    timerVal  = LD_HOLD;
                end
            end
            ST_A_HOLD: begin
                if (timerDone) begin
                    nextState = ST_D_SETUP;
                    timerLoad = 1'b1;
                    timerVal  = LD_SETUP;
                end
            end
            ST_D_SETUP: begin
                if (timerDone) begin
                    nextState = ST_D_STROBE;
                    timerLoad = 1'b1;
                    timerVal  = LD_STROBE;
                end
            end
            ST_D_STROBE: begin
                if (timerDone) begin
                    nextState = ST_D_HOLD;
                    timerLoad = 1'b1;
                    timerVal  = LD_HOLD;
                end
            end
            ST_D_HOLD: begin
                if (timerDone) begin
                    nextState = ST_GAP;
                    timerLoad = 1'b1;
                    timerVal  = LD_GAP;
                end
            end
            ST_GAP: begin
                if (timerDone) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            opReg     <= OP_WR;
            lastGrant <= OP_RD;
            addrReg   <= '0;
            dataReg   <= '0;
            capReg    <= '0;
            rd_data   <= '0;
            wr_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            ad        <= 1'b1;
            dir       <= 1'b1;
            bus_out   <= '0;
            busy      <= 1'b0;
        end else begin
            state    <= nextState;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;

            if (state == ST_IDLE && nextState == ST_A_SETUP) begin
                opReg     <= grantOp;
                lastGrant <= grantOp;
                addrReg   <= curAddr;
                dataReg   <= wr_data;
            end

            if (state == ST_D_STROBE && timerDone && opReg == OP_RD) begin
                capReg <= bus_in;
            end

            if (state == ST_D_HOLD && nextState == ST_GAP) begin
                if (opReg == OP_WR) begin
                    wr_ack <= 1'b1;
                end else begin
                    rd_valid <= 1'b1;
                    rd_data  <= capReg;
                end
            end

            busy <= (nextState != ST_IDLE);
            cs_n <= (nextState == ST_IDLE) || (nextState == ST_GAP);
            ad   <= !((nextState == ST_A_SETUP) || (nextState == ST_A_STROBE) ||
                      (nextState == ST_A_HOLD));
            wr_n <= !((nextState == ST_A_STROBE) ||
                      (nextState == ST_D_STROBE && curOp == OP_WR));
            rd_n <= !(nextState == ST_D_STROBE && curOp == OP_RD);

            case (nextState)
                ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                    dir     <= 1'b1;
                    bus_out <= curAddr;
                end
                ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                    dir     <= (curOp == OP_WR);
                    bus_out <= (curOp == OP_WR) ? curData : '0;
                end
                default: begin
                    dir     <= 1'b1;
                    bus_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - self-checking bench for rtc_bus_sequencer (default and fast timing)
module tb_rtc_bus_sequencer;

    localparam int NI = 2;
    localparam logic [15:0] IDLE_VEC = 16'hF800;

    int tS  [NI] = '{2, 2};
    int tSt [NI] = '{6, 1};
    int tH  [NI] = '{2, 2};
    int tG  [NI] = '{2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetLine [NI];
    logic       wrReq     [NI];
    logic       rdReq     [NI];
    logic [7:0] wrAddr    [NI];
    logic [7:0] wrData    [NI];
    logic [7:0] rdAddr    [NI];
    logic [7:0] busIn     [NI];
    logic       wrAck     [NI];
    logic       rdValid   [NI];
    logic       csN       [NI];
    logic       rdN       [NI];
    logic       wrN       [NI];
    logic       ad        [NI];
    logic       dir       [NI];
    logic       busy      [NI];
    logic [7:0] rdData    [NI];
    logic [7:0] busOut    [NI];

    int         checks = 0;
    int         failures = 0;
    bit         lastRd     [NI];
    logic [7:0] expRdData  [NI];

    rtc_bus_sequencer #(
        .T_SETUP(2), .T_STROBE(6), .T_HOLD(2), .T_GAP(2), .DW(8)
    ) dut (
        .clk(clk), .reset(resetLine[0]),
        .wr_req(wrReq[0]), .wr_addr(wrAddr[0]), .wr_data(wrData[0]), .wr_ack(wrAck[0]),
        .rd_req(rdReq[0]), .rd_addr(rdAddr[0]), .rd_data(rdData[0]), .rd_valid(rdValid[0]),
        .cs_n(csN[0]), .rd_n(rdN[0]), .wr_n(wrN[0]), .ad(ad[0]), .dir(dir[0]),
        .bus_out(busOut[0]), .bus_in(busIn[0]), .busy(busy[0])
    );

    rtc_bus_sequencer #(
        .T_SETUP(2), .T_STROBE(1), .T_HOLD(2), .T_GAP(1), .DW(8)
    ) dutFast (
        .clk(clk), .reset(resetLine[1]),
        .wr_req(wrReq[1]), .wr_addr(wrAddr[1]), .wr_data(wrData[1]), .wr_ack(wrAck[1]),
        .rd_req(rdReq[1]), .rd_addr(rdAddr[1]), .rd_data(rdData[1]), .rd_valid(rdValid[1]),
        .cs_n(csN[1]), .rd_n(rdN[1]), .wr_n(wrN[1]), .ad(ad[1]), .dir(dir[1]),
        .bus_out(busOut[1]), .bus_in(busIn[1]), .busy(busy[1])
    );

    function automatic logic [15:0] obsVec(input int s);
        return {csN[s], rdN[s], wrN[s], ad[s], dir[s], busy[s], wrAck[s], rdValid[s], busOut[s]};
    endfunction

    // Expected pins k cycles after the grant edge, from phase lengths alone.
    function automatic logic [15:0] expWave(input int s, input int k, input bit isWr,
                                            input logic [7:0] a, input logic [7:0] d);
        int         ph;
        int         j;
        bit         dataPh;
        bit         strobe;
        logic [15:0] v;
        ph = tS[s] + tSt[s] + tH[s];
        if (k > 2 * ph) begin
            return {5'b11111, 1'b1, (k == 2 * ph + 1) && isWr, (k == 2 * ph + 1) && !isWr, 8'h00};
        end
        dataPh = (k > ph);
        j      = dataPh ? k - ph : k;
        strobe = (j > tS[s]) && (j <= tS[s] + tSt[s]);
        v[15]  = 1'b0;
        v[14]  = !(strobe && dataPh && !isWr);
        v[13]  = !(strobe && (!dataPh || isWr));
        v[12]  = dataPh;
        v[11]  = !dataPh || isWr;
        v[10]  = 1'b1;
        v[9]   = 1'b0;
        v[8]   = 1'b0;
        v[7:0] = !dataPh ? a : (isWr ? d : 8'h00);
        return v;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at an IDLE-cycle negedge; returns at the following IDLE negedge (or at abortAt).
    task automatic runTxn(input int s, input bit keepReq, input int abortAt, input int busVal);
        bit         isWr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] capt;
        int         ph;
        int         tot;
        int         kCap;
        isWr      = wrReq[s] && (!rdReq[s] || lastRd[s]);
        lastRd[s] = !isWr;
        a    = isWr ? wrAddr[s] : rdAddr[s];
        d    = wrData[s];
        ph   = tS[s] + tSt[s] + tH[s];
        tot  = 2 * ph + tG[s];
        kCap = ph + tS[s] + tSt[s];
        capt = 8'h00;
        for (int k = 1; k <= tot; k++) begin
            @(negedge clk);
            check($sformatf("wave s%0d k%0d %s", s, k, isWr ? "wr" : "rd"),
                  obsVec(s), expWave(s, k, isWr, a, d));
            check($sformatf("strobe overlap s%0d k%0d", s, k),
                  {15'd0, !rdN[s] && !wrN[s]}, 16'd0);
            busIn[s] = (busVal >= 0) ? 8'(busVal) : 8'($urandom);
            if (k == kCap) capt = busIn[s];
            if (k == 4) begin
                wrAddr[s] = 8'($urandom);
                wrData[s] = 8'($urandom);
                rdAddr[s] = 8'($urandom);
            end
            if (k == 2 * ph + 1) begin
                if (!isWr) expRdData[s] = capt;
                check($sformatf("rd_data at pulse s%0d", s), {8'h00, rdData[s]}, {8'h00, expRdData[s]});
                if (!keepReq) begin
                    if (isWr) wrReq[s] = 1'b0;
                    else      rdReq[s] = 1'b0;
                end
            end
            if (k == abortAt) return;
        end
        @(negedge clk);
        check($sformatf("idle after txn s%0d", s), obsVec(s), IDLE_VEC);
        check($sformatf("rd_data held s%0d", s), {8'h00, rdData[s]}, {8'h00, expRdData[s]});
    endtask

    initial begin
        int r;
        for (int s = 0; s < NI; s++) begin
            resetLine[s] = 1'b1;
            wrReq[s]     = 1'b0;
            rdReq[s]     = 1'b0;
            wrAddr[s]    = 8'h00;
            wrData[s]    = 8'h00;
            rdAddr[s]    = 8'h00;
            busIn[s]     = 8'h00;
            lastRd[s]    = 1'b1;
            expRdData[s] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            check($sformatf("reset state s%0d", s), obsVec(s), IDLE_VEC);
            check($sformatf("reset rd_data s%0d", s), {8'h00, rdData[s]}, 16'h0000);
            resetLine[s] = 1'b0;
        end
        @(negedge clk);
        check("idle no request", obsVec(0), IDLE_VEC);

        // directed write then read
        wrAddr[0] = 8'h21;
        wrData[0] = 8'h59;
        wrReq[0]  = 1'b1;
        runTxn(0, 1'b0, 0, -1);
        rdAddr[0] = 8'h04;
        rdReq[0]  = 1'b1;
        runTxn(0, 1'b0, 0, 'h37);
        check("read data 0x37", {8'h00, rdData[0]}, 16'h0037);

        // contention from reset: W, R, W while both held
        resetLine[0] = 1'b1;
        @(negedge clk);
        resetLine[0] = 1'b0;
        lastRd[0]    = 1'b1;
        expRdData[0] = 8'h00;
        wrReq[0] = 1'b1;
        rdReq[0] = 1'b1;
        runTxn(0, 1'b1, 0, -1);
        runTxn(0, 1'b1, 0, -1);
        runTxn(0, 1'b1, 0, -1);
        runTxn(0, 1'b0, 0, -1);
        runTxn(0, 1'b0, 0, -1);

        // back-to-back reads
        rdReq[0] = 1'b1;
        runTxn(0, 1'b1, 0, -1);
        runTxn(0, 1'b0, 0, -1);

        // reset during the data strobe of a write
        wrReq[0] = 1'b1;
        runTxn(0, 1'b0, 15, -1);
        resetLine[0] = 1'b1;
        @(negedge clk);
        check("reset mid-op outputs", obsVec(0), IDLE_VEC);
        check("reset mid-op rd_data", {8'h00, rdData[0]}, 16'h0000);
        resetLine[0] = 1'b0;
        lastRd[0]    = 1'b1;
        expRdData[0] = 8'h00;
        runTxn(0, 1'b0, 0, -1);

        // fast timing instance
        wrReq[1] = 1'b1;
        runTxn(1, 1'b0, 0, -1);
        rdReq[1] = 1'b1;
        runTxn(1, 1'b1, 0, -1);
        runTxn(1, 1'b0, 0, -1);

        // randomized request mix on each instance
        for (int s = 0; s < NI; s++) begin
            for (int i = 0; i < 6; i++) begin
                r = int'($urandom_range(1, 3));
                if (r[0] && !wrReq[s]) begin
                    wrReq[s]  = 1'b1;
                    wrAddr[s] = 8'($urandom);
                    wrData[s] = 8'($urandom);
                end
                if (r[1] && !rdReq[s]) begin
                    rdReq[s]  = 1'b1;
                    rdAddr[s] = 8'($urandom);
                end
                runTxn(s, 1'b0, 0, -1);
            end
            wrReq[s] = 1'b0;
            rdReq[s] = 1'b0;
            @(negedge clk);
            check($sformatf("quiet after random s%0d", s), obsVec(s), IDLE_VEC);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
